fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 124 ++++++++++++
 tb/tb_fetch_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, instruction register and the ID/EX/WB opcode
// tracking slots, with a saturating stall counter and a terminal halt.

module fetch_stage_op #(
  parameter logic [3:0] NOP_OP = 4'b0000
) (
  input  logic       vld,
  input  logic [3:0] op_field,
  output logic [3:0] opcode
);
  assign opcode = vld ? op_field : NOP_OP;
endmodule

module fetch_stage #(
  parameter int         IMEM_SIZE = 32,
  parameter logic [3:0] NOP_OP    = 4'b0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_inc,
  input  logic        pc_sel,
  input  logic        pc_load,
  input  logic        pc_rst_n,
  input  logic        ir_wr,
  input  logic        holt,
  input  logic [15:0] jump_target,
  input  logic [15:0] ret_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] imem_addr,
  output logic [15:0] pc_val,
  output logic [15:0] pc_plus1,
  output logic [3:0]  if_opcode,
  output logic [3:0]  id_opcode,
  output logic [3:0]  ex_opcode,
  output logic [3:0]  wb_opcode,
  output logic [15:0] id_instr,
  output logic [15:0] ex_instr,
  output logic        id_vld,
  output logic        ex_vld,
  output logic        wb_vld,
  output logic [15:0] stall_cnt
);

  localparam int STAGES = 3;  // IF(ir)=0, ID=1, EX=2, WB=3

  typedef struct packed {
    logic rst_n;
    logic load;
    logic sel;
    logic inc;
  } pc_ctrl_t;

  if (IMEM_SIZE < 1 || IMEM_SIZE > 65536) begin : g_bad_size
    $error("fetch_stage: IMEM_SIZE out of range");
  end

  pc_ctrl_t               ctrl;
  logic [15:0]            pc, pc_nxt;
  logic [2:0][15:0]       instr_pipe;  // [0]=ir, [1]=ID, [2]=EX
  logic [3:0]             wb_op;       // WB only ever needs the opcode field
  logic [STAGES:0]        vld_pipe;    // [0]=if_vld
  logic [STAGES:0][3:0]   op_field;
  logic [STAGES:0][3:0]   opcode;
  logic                   stall;

  assign ctrl = '{rst_n: pc_rst_n, load: pc_load, sel: pc_sel, inc: pc_inc};

  always_comb begin
    pc_nxt = pc;
    if (!ctrl.rst_n)   pc_nxt = '0;
    else if (ctrl.load) pc_nxt = ctrl.sel ? ret_addr : jump_target;
    else if (ctrl.inc)  pc_nxt = pc + 16'd1;
  end

  assign stall = !ctrl.inc && !ctrl.load;

  // Every non-halted edge moves ir into ID, so if_vld simply follows ir_wr;
  // that is what keeps a word from entering ID twice across stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= '0;
      instr_pipe <= '0;
      wb_op      <= '0;
      vld_pipe   <= '0;
      stall_cnt  <= '0;
    end else if (!holt) begin
      pc <= pc_nxt;
      if (ir_wr) instr_pipe[0] <= imem_data;
      vld_pipe[0]            <= ir_wr;
      instr_pipe[1]          <= vld_pipe[0] ? instr_pipe[0] : 16'h0000;
      instr_pipe[2]          <= instr_pipe[1];
      wb_op                  <= instr_pipe[2][15:12];
      vld_pipe[STAGES:1]     <= vld_pipe[STAGES-1:0];
      if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_field
    assign op_field[s] = instr_pipe[s][15:12];
  end
  assign op_field[STAGES] = wb_op;

  for (genvar s = 0; s <= STAGES; s++) begin : g_op
    fetch_stage_op #(.NOP_OP(NOP_OP)) u_op (
      .vld      (vld_pipe[s]),
      .op_field (op_field[s]),
      .opcode   (opcode[s])
    );
  end

  assign imem_addr = pc;
  assign pc_val    = pc;
  assign pc_plus1  = pc + 16'd1;
  assign if_opcode = opcode[0];
  assign id_opcode = opcode[1];
  assign ex_opcode = opcode[2];
  assign wb_opcode = opcode[3];
  assign id_instr  = instr_pipe[1];
  assign ex_instr  = instr_pipe[2];
  assign id_vld    = vld_pipe[1];
  assign ex_vld    = vld_pipe[2];
  assign wb_vld    = vld_pipe[3];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a scoreboard that tracks
// every loaded word through EX and WB.

module tb_fetch_stage;
  localparam int         IMEM_SIZE = 32;
  localparam logic [3:0] NOP = 4'b0000;

  logic        clk = 1'b0;
  logic        rst_n, pc_inc, pc_sel, pc_load, pc_rst_n, ir_wr, holt;
  logic [15:0] jump_target, ret_addr, imem_data;
  logic [15:0] imem_addr, pc_val, pc_plus1, id_instr, ex_instr, stall_cnt;
  logic [3:0]  if_opcode, id_opcode, ex_opcode, wb_opcode;
  logic        id_vld, ex_vld, wb_vld;

  int checks = 0;
  int errors = 0;
  logic [15:0] exq[$];
  logic [3:0]  wbq[$];

  fetch_stage #(.IMEM_SIZE(IMEM_SIZE), .NOP_OP(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .pc_inc(pc_inc), .pc_sel(pc_sel),
    .pc_load(pc_load), .pc_rst_n(pc_rst_n), .ir_wr(ir_wr), .holt(holt),
    .jump_target(jump_target), .ret_addr(ret_addr), .imem_data(imem_data),
    .imem_addr(imem_addr), .pc_val(pc_val), .pc_plus1(pc_plus1),
    .if_opcode(if_opcode), .id_opcode(id_opcode), .ex_opcode(ex_opcode),
    .wb_opcode(wb_opcode), .id_instr(id_instr), .ex_instr(ex_instr),
    .id_vld(id_vld), .ex_vld(ex_vld), .wb_vld(wb_vld), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One clock; afterwards retire scoreboard entries that moved into EX/WB.
  task automatic tick();
    logic        adv, ld;
    logic [15:0] w, e;
    logic [3:0]  o;
    adv = rst_n && !holt;
    ld  = ir_wr;
    w   = imem_data;
    @(posedge clk); #1;
    if (adv) begin
      if (ex_vld) begin
        if (exq.size() == 0) chk("sb_ex_unexpected", ex_instr, 16'h0);
        else begin
          e = exq.pop_front();
          chk("sb_ex", ex_instr, e);
          wbq.push_back(e[15:12]);
        end
      end
      if (wb_vld) begin
        if (wbq.size() == 0) chk("sb_wb_unexpected", wb_opcode, 4'h0);
        else begin
          o = wbq.pop_front();
          chk("sb_wb", wb_opcode, o);
        end
      end
      if (ld) exq.push_back(w);
    end
  endtask

  task automatic idle_inputs();
    pc_inc = 0; pc_sel = 0; pc_load = 0; pc_rst_n = 1; ir_wr = 0; holt = 0;
    jump_target = 0; ret_addr = 0; imem_data = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    exq.delete();
    wbq.delete();
    rst_n = 1;
  endtask

  function automatic logic [114:0] snap();
    return {pc_val, pc_plus1, if_opcode, id_opcode, ex_opcode, wb_opcode,
            id_instr, ex_instr, id_vld, ex_vld, wb_vld, stall_cnt};
  endfunction

  initial begin
    logic [15:0] words [4];
    logic [114:0] frozen;
    logic [15:0] exp_pc, exp_stall;

    words[0] = 16'h0123; words[1] = 16'h1456; words[2] = 16'h2789; words[3] = 16'h3ABC;
    do_reset();

    // reset state
    chk("rst_pc", pc_val, 16'h0);
    chk("rst_imem_addr", imem_addr, 16'h0);
    chk("rst_vld", {id_vld, ex_vld, wb_vld}, 3'b000);
    chk("rst_ops", {if_opcode, id_opcode, ex_opcode, wb_opcode}, {4{NOP}});
    chk("rst_stall", stall_cnt, 16'h0);

    // sequential fetch of four words
    for (int i = 0; i < 4; i++) begin
      pc_inc = 1; ir_wr = 1; imem_data = words[i];
      chk($sformatf("seq_pc%0d", i), pc_val, 16'(i));
      tick();
    end
    chk("seq_pc4", pc_val, 16'd4);
    chk("seq_wb_op", wb_opcode, 4'h0);
    chk("seq_wb_vld", wb_vld, 1'b1);
    chk("seq_id_instr", id_instr, 16'h2789);
    chk("seq_ex_instr", ex_instr, 16'h1456);
    chk("seq_if_op", if_opcode, 4'h3);

    // jump and return
    pc_inc = 0; ir_wr = 0; pc_load = 1; pc_sel = 0; jump_target = 16'h0010; ret_addr = 16'h0007;
    tick();
    chk("jmp_pc", pc_val, 16'h0010);
    chk("jmp_plus1", pc_plus1, 16'h0011);
    pc_sel = 1;
    tick();
    chk("ret_pc", pc_val, 16'h0007);
    pc_load = 0; pc_sel = 1; pc_inc = 1;
    tick();
    chk("sel_ignored", pc_val, 16'h0008);
    chk("no_stall_counted", stall_cnt, 16'h0);

    // single word moving through a stalled pipeline
    do_reset();
    pc_inc = 1; ir_wr = 1; imem_data = 16'h9005;
    tick();
    pc_inc = 0; ir_wr = 0; imem_data = 16'hFFFF;
    tick();
    chk("st1_ops", {id_opcode, ex_opcode, wb_opcode}, {4'h9, NOP, NOP});
    chk("st1_if_op", if_opcode, NOP);
    tick();
    chk("st2_ops", {id_opcode, ex_opcode, wb_opcode}, {NOP, 4'h9, NOP});
    chk("st2_id_instr", id_instr, 16'h0000);
    tick();
    chk("st3_ops", {id_opcode, ex_opcode, wb_opcode}, {NOP, NOP, 4'h9});
    chk("st3_stall", stall_cnt, 16'd3);
    tick();
    chk("st4_ops", {id_opcode, ex_opcode, wb_opcode}, {NOP, NOP, NOP});
    chk("st4_vld", {id_vld, ex_vld, wb_vld}, 3'b000);

    // pc boundaries
    pc_load = 1; pc_sel = 0; jump_target = 16'(IMEM_SIZE);
    tick();
    chk("pc_imem_size", pc_val, 16'(IMEM_SIZE));
    pc_rst_n = 0; jump_target = 16'h0005;
    tick();
    chk("pc_rst_wins", pc_val, 16'h0);
    pc_rst_n = 1; jump_target = 16'hFFFF;
    tick();
    chk("pc_ffff", pc_val, 16'hFFFF);
    chk("plus1_wrap", pc_plus1, 16'h0000);
    pc_load = 0; pc_inc = 1;
    tick();
    chk("pc_wrap", pc_val, 16'h0000);

    // halt freezes everything, reset recovers
    do_reset();
    pc_inc = 1; ir_wr = 1;
    imem_data = 16'hA111; tick();
    imem_data = 16'hB222; tick();
    pc_inc = 0; imem_data = 16'hC333; tick();
    frozen = snap();
    holt = 1; pc_inc = 1; pc_load = 1; imem_data = 16'h7777;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("halt_frozen%0d", i), snap(), frozen);
    end
    #3 rst_n = 0;
    #1;
    chk("async_rst_pc", pc_val, 16'h0);
    chk("async_rst_vld", {id_vld, ex_vld, wb_vld}, 3'b000);
    chk("async_rst_stall", stall_cnt, 16'h0);
    exq.delete();
    wbq.delete();
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1;
    pc_inc = 1; ir_wr = 1; imem_data = 16'hD444;
    tick();
    chk("resume_pc", pc_val, 16'h0001);
    chk("resume_if_op", if_opcode, 4'hD);

    // random traffic with pc and stall models
    do_reset();
    exp_pc = 0; exp_stall = 0;
    for (int i = 0; i < 200; i++) begin
      pc_inc      = 1'($urandom_range(0, 1));
      ir_wr       = 1'($urandom_range(0, 1));
      pc_load     = ($urandom_range(0, 7) == 0);
      pc_sel      = 1'($urandom_range(0, 1));
      pc_rst_n    = ($urandom_range(0, 15) != 0);
      jump_target = 16'($urandom);
      ret_addr    = 16'($urandom);
      imem_data   = 16'($urandom);
      if (!pc_rst_n)    exp_pc = 16'h0;
      else if (pc_load) exp_pc = pc_sel ? ret_addr : jump_target;
      else if (pc_inc)  exp_pc = exp_pc + 16'd1;
      if (!pc_inc && !pc_load) exp_stall = exp_stall + 16'd1;
      tick();
      if (pc_val !== exp_pc) chk($sformatf("rnd_pc%0d", i), pc_val, exp_pc);
    end
    chk("rnd_pc_final", pc_val, exp_pc);
    chk("rnd_stall", stall_cnt, exp_stall);
    idle_inputs();
    pc_inc = 1;
    repeat (4) tick();
    chk("sb_drained", {16'(exq.size()), 16'(wbq.size())}, 32'h0);

    // stall counter saturation
    do_reset();
    repeat (65534) tick();
    chk("stall_fffe", stall_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall_sat%0d", i), stall_cnt, 16'hFFFF);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
